// File: rtl/display_cuenta_7seg.sv
// ============================================================================
// Module      : display_cuenta_7seg
// Description : Shows a captured 0..15 counter value in decimal on two
//               time-multiplexed 7-segment digits, with blanking gaps between
//               digits, leading-zero suppression and a wrap indicator on dp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_cuenta_7seg #(
  parameter int REFRESH_DIV        = 50000,
  parameter int BLANK_CYCLES       = 500,
  parameter int ACTIVE_LOW         = 1,
  parameter int BLANK_LEADING_ZERO = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] cont,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic [3:0] valor
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] BLANK_RELOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] ON_RELOAD    = TW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [6:0]    SEG_POL      = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_POL       = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;
  localparam logic          DP_POL       = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    BLANK_U = 2'd0,
    ON_U    = 2'd1,
    BLANK_T = 2'd2,
    ON_T    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      valor_q, valor_d;
  logic            wrap_q, wrap_d;
  logic [3:0]      sh_units_q, sh_units_d;
  logic            sh_tens_q, sh_tens_d;
  logic            sh_wrap_q, sh_wrap_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;
  logic            dp_q, dp_d;

  logic            tens;
  logic [3:0]      units;
  logic [6:0]      seg_raw;
  logic [1:0]      an_raw;
  logic            dp_raw;

  function automatic logic [6:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 7'b0111111;
      4'd1:    pattern = 7'b0000110;
      4'd2:    pattern = 7'b1011011;
      4'd3:    pattern = 7'b1001111;
      4'd4:    pattern = 7'b1100110;
      4'd5:    pattern = 7'b1101101;
      4'd6:    pattern = 7'b1111101;
      4'd7:    pattern = 7'b0000111;
      4'd8:    pattern = 7'b1111111;
      4'd9:    pattern = 7'b1101111;
      default: pattern = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    valor_d = valor_q;
    wrap_d  = wrap_q;
    if (load) begin
      valor_d = cont;
      if (valor_q == 4'd15 && cont == 4'd0) begin
        wrap_d = 1'b1;
      end else if (cont != 4'd0) begin
        wrap_d = 1'b0;
      end
    end

    tens  = (valor_q >= 4'd10);
    units = tens ? (valor_q - 4'd10) : valor_q;

    state_d    = state_q;
    timer_d    = timer_q - 1'b1;
    sh_units_d = sh_units_q;
    sh_tens_d  = sh_tens_q;
    sh_wrap_d  = sh_wrap_q;
    if (timer_q == '0) begin
      case (state_q)
        BLANK_U: begin
          state_d    = ON_U;
          timer_d    = ON_RELOAD;
          sh_units_d = units;
          sh_wrap_d  = wrap_q;
        end
        ON_U: begin
          state_d = BLANK_T;
          timer_d = BLANK_RELOAD;
        end
        BLANK_T: begin
          state_d   = ON_T;
          timer_d   = ON_RELOAD;
          sh_tens_d = tens;
        end
        default: begin
          state_d = BLANK_U;
          timer_d = BLANK_RELOAD;
        end
      endcase
    end

    // Outputs follow the next state so they switch on the same edge as the FSM.
    an_raw  = 2'b00;
    seg_raw = 7'b0000000;
    dp_raw  = 1'b0;
    case (state_d)
      ON_U: begin
        an_raw  = 2'b01;
        seg_raw = pattern(sh_units_d);
        dp_raw  = sh_wrap_d;
      end
      ON_T: begin
        if (sh_tens_d || (BLANK_LEADING_ZERO == 0)) begin
          an_raw  = 2'b10;
          seg_raw = pattern({3'b000, sh_tens_d});
        end
      end
      default: begin
        an_raw = 2'b00;
      end
    endcase
    an_d  = an_raw ^ AN_POL;
    seg_d = seg_raw ^ SEG_POL;
    dp_d  = dp_raw ^ DP_POL;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BLANK_U;
      timer_q    <= BLANK_RELOAD;
      valor_q    <= 4'd0;
      wrap_q     <= 1'b0;
      sh_units_q <= 4'd0;
      sh_tens_q  <= 1'b0;
      sh_wrap_q  <= 1'b0;
      seg_q      <= SEG_POL;
      an_q       <= AN_POL;
      dp_q       <= DP_POL;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      valor_q    <= valor_d;
      wrap_q     <= wrap_d;
      sh_units_q <= sh_units_d;
      sh_tens_q  <= sh_tens_d;
      sh_wrap_q  <= sh_wrap_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dp_q       <= dp_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign valor = valor_q;

endmodule

`default_nettype wire

// File: tb/tb_display_cuenta_7seg.sv
// ============================================================================
// Module      : tb_display_cuenta_7seg
// Description : Self-checking bench for display_cuenta_7seg, two instances
//               differing only in leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_cuenta_7seg;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] cont = 4'd0;
  logic [6:0] seg, seg_z;
  logic [1:0] an, an_z;
  logic       dp, dp_z;
  logic [3:0] valor, valor_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] pat [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                           7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  display_cuenta_7seg #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1),
                        .BLANK_LEADING_ZERO(1)) dut (
    .clock(clock), .reset_n(reset_n), .cont(cont), .load(load),
    .seg(seg), .an(an), .dp(dp), .valor(valor));

  display_cuenta_7seg #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1),
                        .BLANK_LEADING_ZERO(0)) dut_z (
    .clock(clock), .reset_n(reset_n), .cont(cont), .load(load),
    .seg(seg_z), .an(an_z), .dp(dp_z), .valor(valor_z));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in the 16-cycle scan counted from reset release,
  // plus the held value, wrap flag and per-digit snapshots.
  int         m_n   = 0;
  logic [3:0] m_v   = 0;
  logic       m_w   = 0;
  logic [3:0] m_su  = 0;
  logic       m_sw  = 0;
  logic [3:0] m_st  = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_v = 0; m_w = 0; m_su = 0; m_sw = 0; m_st = 0;
    end else begin
      if ((m_n + 1) % 16 == 2) begin m_su = m_v; m_sw = m_w; end
      if ((m_n + 1) % 16 == 10) m_st = m_v;
      m_n = m_n + 1;
      if (load) begin
        if (m_v == 15 && cont == 0) m_w = 1'b1;
        else if (cont != 0) m_w = 1'b0;
        m_v = cont;
      end
    end
  end

  always @(negedge clock) begin
    int p;
    logic [1:0] ean, ean_z;
    logic [6:0] eseg, eseg_z;
    logic       edp;
    p = m_n % 16;
    ean = 2'b11; eseg = 7'h7F; edp = 1'b1;
    if (p >= 2 && p < 8) begin
      ean = 2'b10; eseg = ~pat[m_su % 10]; edp = ~m_sw;
    end else if (p >= 10 && (m_st / 10) != 0) begin
      ean = 2'b01; eseg = ~pat[m_st / 10];
    end
    ean_z = ean; eseg_z = eseg;
    if (p >= 10 && (m_st / 10) == 0) begin
      ean_z = 2'b01; eseg_z = ~pat[0];
    end
    chk("an",       {14'b0, an},    {14'b0, ean});
    chk("seg",      {9'b0, seg},    {9'b0, eseg});
    chk("dp",       {15'b0, dp},    {15'b0, edp});
    chk("valor",    {12'b0, valor}, {12'b0, m_v});
    chk("an_z",     {14'b0, an_z},  {14'b0, ean_z});
    chk("seg_z",    {9'b0, seg_z},  {9'b0, eseg_z});
    chk("dp_z",     {15'b0, dp_z},  {15'b0, edp});
    chk("an_legal", {15'b0, (an == 2'b00) || (an_z == 2'b00)}, 16'd0);
  end

  task automatic wait_pos(input int p);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (m_n % 16 == p) found = 1;
    end
    if (!found) begin
      n_checks++; n_fail++;
      $display("FAIL wait_pos: position %0d not reached within 40 cycles", p);
    end
  endtask

  task automatic settle();
    repeat (17) @(negedge clock);
  endtask

  initial begin
    int edges;
    repeat (3) @(negedge clock);
    chk("rst_an", {14'b0, an}, 16'h0003);
    chk("rst_seg", {9'b0, seg}, 16'h007F);
    reset_n = 1'b1;

    // 2: value 7
    load = 1'b1; cont = 4'd7;
    @(negedge clock); load = 1'b0;
    settle();
    wait_pos(3);
    chk("v7_u_an", {14'b0, an}, 16'b10);
    chk("v7_u_seg", {9'b0, seg}, {9'b0, 7'b1111000});
    wait_pos(11);
    chk("v7_t_an", {14'b0, an}, 16'b11);

    // 3: value 13
    load = 1'b1; cont = 4'd13;
    @(negedge clock); load = 1'b0;
    settle();
    wait_pos(3);
    chk("v13_u_an", {14'b0, an}, 16'b10);
    chk("v13_u_seg", {9'b0, seg}, {9'b0, 7'b0110000});
    wait_pos(11);
    chk("v13_t_an", {14'b0, an}, 16'b01);
    chk("v13_t_seg", {9'b0, seg}, {9'b0, 7'b1111001});

    // 1: async reset in ON_T, then blank length after release
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an", {14'b0, an}, 16'b11);
    chk("arst_seg", {9'b0, seg}, 16'h007F);
    chk("arst_dp", {15'b0, dp}, 16'd1);
    chk("arst_valor", {12'b0, valor}, 16'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    edges = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      edges++;
      if (an != 2'b11) break;
    end
    chk("rel_blank_edges", edges[15:0], 16'd2);

    // 5: wrap with continuous load
    @(negedge clock);
    load = 1'b1; cont = 4'd15;
    repeat (2) @(negedge clock);
    cont = 4'd0;
    settle();
    wait_pos(3);
    chk("wrap_dp_on", {15'b0, dp}, 16'd0);
    cont = 4'd1;
    settle();
    wait_pos(3);
    chk("wrap_dp_off", {15'b0, dp}, 16'd1);

    // 6: load low sweep, then leading zero shown, then mid-slot capture
    load = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cont = c[3:0];
      @(negedge clock);
    end
    chk("hold_valor", {12'b0, valor}, 16'd1);
    load = 1'b1; cont = 4'd5;
    @(negedge clock); load = 1'b0;
    settle();
    wait_pos(11);
    chk("lz_an_z", {14'b0, an_z}, 16'b01);
    chk("lz_seg_z", {9'b0, seg_z}, {9'b0, 7'b1000000});
    chk("lz_an", {14'b0, an}, 16'b11);
    wait_pos(4);
    load = 1'b1; cont = 4'd9;
    @(negedge clock); load = 1'b0;
    chk("mid_valor", {12'b0, valor}, 16'd9);
    wait_pos(6);
    chk("mid_seg_hold", {9'b0, seg}, {9'b0, 7'b0010010});
    wait_pos(3);
    chk("mid_seg_new", {9'b0, seg}, {9'b0, 7'b0010000});

    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
